// File: rtl/stack_alu_param.sv
// stack_alu_param: one-op-per-cycle signed stack ALU with configurable width and depth.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, opcode         op strobe and 3-bit opcode (NOP SUB DUP SWAP ADD MUL PUSH POP)
//   input_data [N]           operand for PUSH
//   output_data [N]          registered result, held until the next producing op
//   out_valid, overflow      one-cycle result / signed-overflow pulses
//   error                    one-cycle pulse when an accepted op is rejected
//   count, empty, full       stack occupancy status
module stack_alu_param #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [2:0]                   opcode,
    input  logic [N-1:0]                 input_data,
    output logic [N-1:0]                 output_data,
    output logic                         out_valid,
    output logic                         overflow,
    output logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [2:0] {
        OP_NOP, OP_SUB, OP_DUP, OP_SWAP, OP_ADD, OP_MUL, OP_PUSH, OP_POP
    } op_e;
    logic [N-1:0]    mem_q [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [N-1:0]    out_q, out_d;
    logic            vld_q, vld_d, ovf_q, ovf_d, err_q, err_d;
    logic [PW-1:0]   t_idx, s_idx, p_idx, wa_idx;
    logic [N-1:0]    t, s, r, wa_data;
    logic            wa_en, wb_en, has1, has2, is_full, r_ovf;
    logic [N:0]      sum, dif;
    logic [2*N-1:0]  prod;
    op_e             op;
    assign op      = op_e'(opcode);
    assign t_idx   = PW'(count_q - CW'(1));
    assign s_idx   = PW'(count_q - CW'(2));
    assign p_idx   = PW'(count_q);
    assign t       = mem_q[t_idx];
    assign s       = mem_q[s_idx];
    assign has1    = count_q != '0;
    assign has2    = count_q > CW'(1);
    assign is_full = count_q == CW'(DEPTH);
    // Operands are sign-extended by hand so the unsigned arithmetic yields the exact signed result.
    assign sum  = {s[N-1], s} + {t[N-1], t};
    assign dif  = {s[N-1], s} - {t[N-1], t};
    assign prod = {{N{s[N-1]}}, s} * {{N{t[N-1]}}, t};
    assign r     = op == OP_SUB ? dif[N-1:0] : op == OP_MUL ? prod[N-1:0] : sum[N-1:0];
    // Product fits in N bits only when its top N+1 bits are a pure sign extension.
    assign r_ovf = op == OP_SUB ? dif[N] ^ dif[N-1] :
                   op == OP_MUL ? ~(&prod[2*N-1:N-1] | ~|prod[2*N-1:N-1]) : sum[N] ^ sum[N-1];
    always_comb begin
        count_d = count_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        wa_en   = 1'b0;
        wa_idx  = p_idx;
        wa_data = input_data;
        wb_en   = 1'b0;
        if (in_valid) begin
            case (op)
                OP_PUSH: begin
                    err_d   = is_full;
                    wa_en   = !is_full;
                    count_d = is_full ? count_q : count_q + CW'(1);
                end
                OP_DUP: begin
                    err_d   = is_full || !has1;
                    wa_en   = !err_d;
                    wa_data = t;
                    count_d = err_d ? count_q : count_q + CW'(1);
                end
                OP_POP: begin
                    err_d   = !has1;
                    vld_d   = has1;
                    out_d   = has1 ? t : out_q;
                    count_d = has1 ? count_q - CW'(1) : count_q;
                end
                OP_SWAP: begin
                    err_d   = !has2;
                    wa_en   = has2;
                    wa_idx  = t_idx;
                    wa_data = s;
                    wb_en   = has2;
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    err_d   = !has2;
                    vld_d   = has2;
                    ovf_d   = has2 && r_ovf;
                    out_d   = has2 ? r : out_q;
                    wa_en   = has2;
                    wa_idx  = s_idx;
                    wa_data = r;
                    count_d = has2 ? count_q - CW'(1) : count_q;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end
    // Storage has no reset; wb only serves SWAP, always at a different index than wa.
    always_ff @(posedge clk) begin
        if (wa_en) mem_q[wa_idx] <= wa_data;
        if (wb_en) mem_q[s_idx] <= t;
    end
    assign output_data = out_q;
    assign out_valid   = vld_q;
    assign overflow    = ovf_q;
    assign error       = err_q;
    assign count       = count_q;
    assign empty       = count_q == '0;
    assign full        = is_full;
endmodule

// File: doc/stack_alu_param.md
# stack_alu_param

Parametrised stack-based ALU, the next generation of the team's 4-bit stack ALU. It adds configurable data width and stack depth, an input-valid strobe, arithmetic ops that consume their operands, SUB/DUP/SWAP, and explicit full/empty/error status. It sits on the datapath as a single-clock, one-op-per-cycle engine driven by a sequencer that issues opcodes with operands.

## Interface
- N, default 8: data width in bits (signed two's complement), N >= 2.
- DEPTH, default 16: stack entries, power of 2, DEPTH >= 2. Pointer/count widths are derived internally.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  op strobe; opcode/input_data sampled only when high.
- opcode  input  3  operation code (see Operation).
- input_data  input  N  signed operand for PUSH.
- output_data  output  N  signed, registered; holds last result until next producing op.
- out_valid  output  1  one-cycle pulse: output_data updated this cycle.
- overflow  output  1  one-cycle pulse with out_valid on a signed overflow.
- error  output  1  one-cycle pulse: accepted op rejected (underflow/overflow of stack).
- count  output  clog2(DEPTH+1)  number of occupied entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

## Operation
- Opcodes: 000 NOP, 001 SUB, 010 DUP, 011 SWAP, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
- T = top entry, S = entry below T.
- PUSH: needs count < DEPTH; writes input_data as new T, count+1. No out_valid.
- POP: needs count >= 1; output_data = T, out_valid, count-1.
- DUP: needs 1 <= count < DEPTH; pushes copy of T, count+1. No out_valid.
- SWAP: needs count >= 2; exchanges T and S. No out_valid.
- ADD: needs count >= 2; R = S + T. SUB: R = S - T. MUL: R = S * T.
- ADD/SUB/MUL pop both operands and push R (count-1); output_data = R, out_valid pulses.
- R is the low N bits of the exact result. ADD/SUB exact result is computed in N+1 bits; MUL in 2N bits signed.
- overflow = 1 when the exact signed result lies outside [-2^(N-1), 2^(N-1)-1]. For MUL, this means the top N+1 bits of the 2N-bit product are not all equal.
- Precondition failure: error pulses; stack, count, output_data and overflow are unchanged; out_valid = 0.
- NOP, or in_valid = 0: no state change; all pulses low.
- Stack storage is not reset; only the pointer/count and outputs are reset.
- Reading a stack entry above count is never done; its contents are don't-care.

## Timing
- Reset (async assert, sync-released by the system): count=0, empty=1, full=0, output_data=0, out_valid=0, overflow=0, error=0.
- Every accepted op completes in one cycle: results, flags and count are visible after the same clk edge that samples in_valid=1.
- Back-to-back ops every cycle are supported. Each op sees the stack as updated by the previous op; no bubbles and no hazards.
- out_valid, overflow and error are high for exactly one cycle per causing op and drop to 0 on the next edge unless re-asserted.
- empty/full/count are registered and consistent with each other every cycle.
- Reset asserted mid-stream aborts immediately; the first op after release sees an empty stack.
- Boundaries:
  - PUSH/DUP at full: error, count stays DEPTH.
  - POP at empty: error.
  - ADD/SUB/MUL/SWAP with count = 1: error, the single entry is preserved.
  - Pointer never wraps.

## Test plan
- N=4, DEPTH=4: PUSH 3, PUSH 2, ADD -> out_valid, output_data=5, overflow=0, count=1.
- PUSH 7, PUSH 1, ADD -> output_data=-8 (4'b1000), overflow=1.
- PUSH -8, PUSH 1, SUB -> output_data=7, overflow=1.
- PUSH 5, PUSH 2, SUB -> 3, overflow=0.
- PUSH 4, PUSH 4, MUL -> output_data=0, overflow=1.
- PUSH -2, PUSH 3, MUL -> -6, overflow=0.
- PUSH 1..4 -> full=1; then PUSH 5 -> error, count=4; then POP x4 -> outputs 4,3,2,1, empty=1; then POP -> error, output_data still 1.
- PUSH 6, DUP, SWAP, POP -> output_data=6, count=1; then ADD -> error, count=1.
- PUSH 2, PUSH 3, assert rst mid-cycle asynchronously -> count=0, output_data=0 without waiting for clk; after release, POP -> error.
